fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, runs the imem request handshake,
// and applies branch/exception redirects without breaking an outstanding request.
//
// state | meaning
// IDLE  | first cycle out of reset, no request issued
// FETCH | issuing a request at PC (withheld while decode stalls)
// WAIT  | request outstanding, memory not yet ready
// REDIR | request outstanding, redirect target latched until memory completes
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter logic [63:0] EXC_VECTOR = 64'hD8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc_F,
    input  logic [63:0] PCBranch_F,
    input  logic        exc_req,
    input  logic        stall_F,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [63:0] imem_addr_F,
    output logic        instr_valid_F,
    output logic        flush_D,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] redir_pc;
    logic        redirect;
    logic [63:0] target;

    assign redirect    = exc_req | PCSrc_F;
    assign target      = exc_req ? EXC_VECTOR : PCBranch_F;
    assign imem_addr_F = pc;

    // Outputs depend on this cycle's handshake, so they are decoded from state and inputs.
    always_comb begin
        imem_req      = 1'b0;
        instr_valid_F = 1'b0;
        flush_D       = 1'b0;
        case (state)
            FETCH: begin
                imem_req = !stall_F;
                if (redirect)
                    flush_D = 1'b1;
                else if (!stall_F && imem_ready)
                    instr_valid_F = 1'b1;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (redirect)
                    flush_D = 1'b1;
                else if (imem_ready && !stall_F)
                    instr_valid_F = 1'b1;
            end
            REDIR: begin
                imem_req = 1'b1;
                flush_D  = redirect;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            redir_pc <= 64'h0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (redirect) begin
                        if (!imem_req || imem_ready) begin
                            pc <= target;
                        end else begin
                            redir_pc <= target;
                            state    <= REDIR;
                        end
                    end else if (!stall_F) begin
                        if (imem_ready)
                            pc <= pc + 64'd4;
                        else
                            state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc    <= target;
                            state <= FETCH;
                        end else begin
                            redir_pc <= target;
                            state    <= REDIR;
                        end
                    end else if (imem_ready) begin
                        // A stalled completion is dropped and the same address re-fetched.
                        if (!stall_F)
                            pc <= pc + 64'd4;
                        state <= FETCH;
                    end
                end
                REDIR: begin
                    if (imem_ready) begin
                        pc    <= redirect ? target : redir_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        redir_pc <= target;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= 32'h0;
        else if (instr_valid_F && fetch_count != 32'hFFFF_FFFF)
            fetch_count <= fetch_count + 32'd1;
    end

endmodule
